// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command arbiter slice: default widths and
// the transaction state encoding.
package spi_pkg;

  localparam int unsigned SPI_CMD_WIDTH  = 12;
  localparam int unsigned SPI_READ_WIDTH = 8;
  localparam int unsigned CMD_RW_BIT     = SPI_CMD_WIDTH - 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } spi_state_t;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker: first active request after last_grant,
// with wrap-around; returns a one-hot grant plus its index.
module spi_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_grant) + k) % NUM_REQ);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Shares one SPI master between NUM_REQ requesters: round-robin grant, one
// command in flight, completion/timeout tracking and response routing.
module spi_cmd_arbiter
  import spi_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned CMD_WIDTH  = SPI_CMD_WIDTH,
  parameter  int unsigned READ_WIDTH = SPI_READ_WIDTH,
  parameter  int unsigned TIMEOUT    = 1023,
  localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd,
  input  logic [NUM_REQ-1:0]           req_vld,
  output logic [NUM_REQ-1:0]           req_rdy,
  output logic [NUM_REQ-1:0]           rsp_vld,
  output logic [READ_WIDTH-1:0]        rsp_data,
  output logic                         rsp_err,
  output logic [CMD_WIDTH-1:0]         m_cmd,
  output logic                         m_cmd_vld,
  input  logic                         m_cmd_rdy,
  input  logic                         m_read_vld,
  input  logic [READ_WIDTH-1:0]        m_read_data,
  output logic                         busy,
  output logic [IDX_W-1:0]             grant_id
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  spi_state_t              state;
  logic [CMD_WIDTH-1:0]    cmd_buf;
  logic [IDX_W-1:0]        last_grant;
  logic [IDX_W-1:0]        arb_idx;
  logic [NUM_REQ-1:0]      arb_gnt;
  logic                    arb_vld;
  logic [CNT_W-1:0]        tmo_cnt;
  logic                    tmo_hit;
  logic                    is_write;
  logic                    done;
  logic [READ_WIDTH-1:0]   done_data;

  spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arb (
    .req        (req_vld),
    .last_grant (last_grant),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx),
    .gnt_vld    (arb_vld)
  );

  assign req_rdy  = (state == IDLE) ? arb_gnt : '0;
  assign m_cmd    = cmd_buf;
  assign is_write = cmd_buf[CMD_WIDTH-1];
  assign tmo_hit  = (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // Completion is only recognised in WAIT_DONE; it takes priority over a
  // timeout landing on the same cycle.
  always_comb begin
    done      = 1'b0;
    done_data = '0;
    if (state == WAIT_DONE) begin
      if (is_write) begin
        done = m_cmd_rdy;
      end else if (m_read_vld) begin
        done      = 1'b1;
        done_data = m_read_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_buf    <= '0;
      grant_id   <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      tmo_cnt    <= '0;
      m_cmd_vld  <= 1'b0;
      busy       <= 1'b0;
      rsp_vld    <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_vld) begin
            cmd_buf   <= req_cmd[arb_idx*CMD_WIDTH +: CMD_WIDTH];
            grant_id  <= arb_idx;
            tmo_cnt   <= '0;
            m_cmd_vld <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE, WAIT_BUSY, WAIT_DONE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (done || tmo_hit) begin
            state     <= RESP;
            m_cmd_vld <= 1'b0;
            rsp_vld   <= NUM_REQ'(1) << grant_id;
            rsp_data  <= done_data;
            rsp_err   <= !done;
          end else if (state == ISSUE && m_cmd_rdy) begin
            m_cmd_vld <= 1'b0;
            state     <= WAIT_BUSY;
          end else if (state == WAIT_BUSY && !m_cmd_rdy) begin
            state <= WAIT_DONE;
          end
        end
        RESP: begin
          rsp_vld    <= '0;
          rsp_data   <= '0;
          rsp_err    <= 1'b0;
          last_grant <= grant_id;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Scoreboard bench for spi_cmd_arbiter with a behavioural SPI master that
// returns read data = cmd[7:0] ^ 0xE0 and ignores the command in hang_cmd.
module tb_spi_cmd_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned CW = 12;
  localparam int unsigned RW = 8;
  localparam int unsigned TO = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR*CW-1:0] req_cmd;
  logic [NR-1:0]   req_vld;
  logic [NR-1:0]   req_rdy;
  logic [NR-1:0]   rsp_vld;
  logic [RW-1:0]   rsp_data;
  logic            rsp_err;
  logic [CW-1:0]   m_cmd;
  logic            m_cmd_vld;
  logic            m_cmd_rdy;
  logic            m_read_vld;
  logic [RW-1:0]   m_read_data;
  logic            busy;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  spi_cmd_arbiter #(
    .NUM_REQ   (NR),
    .CMD_WIDTH (CW),
    .READ_WIDTH(RW),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_cmd    (req_cmd),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .rsp_vld    (rsp_vld),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .m_cmd      (m_cmd),
    .m_cmd_vld  (m_cmd_vld),
    .m_cmd_rdy  (m_cmd_rdy),
    .m_read_vld (m_read_vld),
    .m_read_data(m_read_data),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  typedef struct {
    int unsigned   id;
    logic [RW-1:0] data;
    logic          err;
    int unsigned   acc;
  } exp_t;

  exp_t          q_rsp[$];
  logic [CW-1:0] q_cmd[$];
  int unsigned   glog[$];
  int unsigned   checks = 0;
  int unsigned   failures = 0;
  int unsigned   cyc = 0;
  int unsigned   rdy_pulses = 0;
  int unsigned   pend[NR];
  logic [CW-1:0] cmd_tbl[NR];
  int unsigned   exp_last;
  logic          mvld_q;
  logic [CW-1:0] hang_cmd = 12'h7FF;
  int unsigned   busy_len = 4;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned pick(input logic [NR-1:0] v, input int unsigned last);
    for (int unsigned k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return NR;
  endfunction

  function automatic int unsigned outstanding();
    int unsigned n = q_rsp.size();
    for (int i = 0; i < NR; i++) n += pend[i];
    return n;
  endfunction

  // Behavioural SPI master: drops ready one cycle after accept, stays busy.
  initial begin
    logic [CW-1:0] c;
    m_cmd_rdy   = 1'b1;
    m_read_vld  = 1'b0;
    m_read_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && m_cmd_vld && m_cmd_rdy && m_cmd != hang_cmd) begin
        c = m_cmd;
        @(posedge clk);
        #1 m_cmd_rdy = 1'b0;
        repeat (busy_len) @(posedge clk);
        #1;
        if (c[CW-1]) begin
          m_cmd_rdy = 1'b1;
        end else begin
          m_read_vld  = 1'b1;
          m_read_data = c[RW-1:0] ^ 8'hE0;
          @(posedge clk);
          #1 m_read_vld = 1'b0;
          m_cmd_rdy = 1'b1;
        end
      end
    end
  end

  task automatic load(input int unsigned i, input logic [CW-1:0] c, input int unsigned n);
    cmd_tbl[i]            = c;
    req_cmd[i*CW +: CW]   = c;
    pend[i]               = n;
    req_vld[i]            = 1'b1;
  endtask

  // One clock: monitor/scoreboard at negedge, request updates after posedge.
  task automatic cycle();
    int unsigned   w;
    exp_t          e;
    logic [NR-1:0] drop;
    drop = '0;
    @(negedge clk);
    if (!rst_n) begin
      q_rsp.delete();
      q_cmd.delete();
      exp_last = NR - 1;
      mvld_q   = 1'b0;
    end else begin
      if (|req_rdy) begin
        w = pick(req_vld, exp_last);
        rdy_pulses++;
        chk("req_rdy", 32'(req_rdy), 32'd1 << w);
        if (w < NR) begin
          glog.push_back(w);
          q_cmd.push_back(cmd_tbl[w]);
          e.id  = w;
          e.err = (cmd_tbl[w] == hang_cmd);
          e.acc = cyc + 1;
          e.data = (e.err || cmd_tbl[w][CW-1]) ? '0 : (cmd_tbl[w][RW-1:0] ^ 8'hE0);
          q_rsp.push_back(e);
          exp_last = w;
          if (pend[w] > 0) pend[w]--;
          if (pend[w] == 0) drop[w] = 1'b1;
        end
      end
      if (m_cmd_vld && !mvld_q) begin
        if (q_cmd.size() == 0) chk("m_cmd_unexp", 32'(m_cmd_vld), 0);
        else chk("m_cmd", 32'(m_cmd), 32'(q_cmd.pop_front()));
      end
      mvld_q = m_cmd_vld;
      if (|rsp_vld) begin
        if (q_rsp.size() == 0) begin
          chk("rsp_unexp", 32'(rsp_vld), 0);
        end else begin
          e = q_rsp.pop_front();
          chk("rsp_vld", 32'(rsp_vld), 32'd1 << e.id);
          chk("grant_id", 32'(grant_id), e.id);
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          if (e.err) chk("tmo_lat", cyc - e.acc, TO);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      req_vld[i] = (pend[i] != 0);
      if (drop[i]) req_cmd[i*CW +: CW] = ~cmd_tbl[i];
    end
  endtask

  task automatic drain(input int unsigned budget);
    for (int unsigned k = 0; k < budget; k++) begin
      cycle();
      if (outstanding() == 0 && !busy && req_vld == '0) break;
    end
    chk("drain_left", outstanding() + (busy ? 1 : 0), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    req_vld  = '0;
    req_cmd  = '0;
    exp_last = NR - 1;
    mvld_q   = 1'b0;
    for (int i = 0; i < NR; i++) begin
      pend[i]    = 0;
      cmd_tbl[i] = '0;
    end
    repeat (2) cycle();
    chk("rst_req_rdy", 32'(req_rdy), 0);
    chk("rst_rsp_vld", 32'(rsp_vld), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_m_cmd_vld", 32'(m_cmd_vld), 0);
    chk("rst_m_cmd", 32'(m_cmd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    rst_n = 1'b1;

    // Write from requester 0, master busy for 40 cycles.
    glog.delete();
    busy_len = 40;
    load(0, 12'h8A5, 1);
    drain(300);
    chk("wr_ngrants", glog.size(), 1);
    chk("wr_grant", glog[0], 0);

    // Read from requester 2.
    glog.delete();
    busy_len = 3;
    load(2, 12'h345, 1);
    drain(200);
    chk("rd_ngrants", glog.size(), 1);
    chk("rd_grant", glog[0], 2);

    // last grant 2, requesters 1 and 3 pending: 3 first.
    glog.delete();
    load(1, 12'h112, 1);
    load(3, 12'h334, 1);
    drain(200);
    chk("rr_ngrants", glog.size(), 2);
    chk("rr_first", glog[0], 3);
    chk("rr_second", glog[1], 1);

    // Master never accepts requester 1's command: timeout, then serve 2.
    glog.delete();
    hang_cmd = 12'h0EE;
    load(1, 12'h0EE, 1);
    cycle();
    load(2, 12'h256, 1);
    drain(400);
    hang_cmd = 12'h7FF;
    chk("tmo_ngrants", glog.size(), 2);
    chk("tmo_first", glog[0], 1);
    chk("tmo_second", glog[1], 2);

    // All four requesters held from reset; requester 0 wants two commands.
    rst_n = 1'b0;
    glog.delete();
    busy_len = 2;
    load(0, 12'h101, 2);
    load(1, 12'h202, 1);
    load(2, 12'h9C3, 1);
    load(3, 12'h404, 1);
    repeat (2) cycle();
    rst_n = 1'b1;
    rdy_pulses = 0;
    drain(600);
    chk("all_ngrants", glog.size(), 5);
    for (int k = 0; k < 5; k++) chk("all_order", glog[k], k % 4);
    chk("all_rdy_pulses", rdy_pulses, 5);

    // Reset while requester 3's read sits in WAIT_DONE.
    glog.delete();
    busy_len = 20;
    load(3, 12'h3C3, 1);
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (busy && !m_cmd_vld && !m_cmd_rdy) break;
    end
    chk("mid_wait", 32'(busy && !m_cmd_vld && !m_cmd_rdy), 1);
    repeat (3) cycle();
    rst_n = 1'b0;
    glog.delete();
    load(0, 12'h0A1, 1);
    load(3, 12'h8B4, 1);
    cycle();
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_m_cmd_vld", 32'(m_cmd_vld), 0);
    chk("mid_rst_rsp_vld", 32'(rsp_vld), 0);
    chk("mid_rst_rsp_err", 32'(rsp_err), 0);
    drain(400);
    chk("mid_ngrants", glog.size(), 2);
    chk("mid_first", glog[0], 0);
    chk("mid_second", glog[1], 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_cmd_arbiter.md
Name: spi_cmd_arbiter

Overview:
Shares one SPI master engine (12-bit command in, 8-bit read data out) between NUM_REQ independent requesters.
- Grants requesters round-robin and issues one command at a time to the master.
- Tracks the transaction to completion, then routes the result back to the granted requester.
- Sits between the control-plane clients and the SPI master. The master never sees more than one outstanding command.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
CMD_WIDTH, 12, command word width; bit CMD_WIDTH-1 = 1 write, 0 read
READ_WIDTH, 8, read data width returned by master
TIMEOUT, 1023, max cycles from ISSUE entry to completion before abort (>=16)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req_cmd  in  NUM_REQ*CMD_WIDTH  packed commands, requester i at [i*CMD_WIDTH +: CMD_WIDTH]
req_vld  in  NUM_REQ  per-requester command valid
req_rdy  out  NUM_REQ  per-requester accept, one-hot or zero
rsp_vld  out  NUM_REQ  one-cycle completion pulse to the granted requester
rsp_data  out  READ_WIDTH  read data, valid with rsp_vld; 0 for writes and aborts
rsp_err  out  1  timeout abort flag, valid with rsp_vld
m_cmd  out  CMD_WIDTH  command to SPI master
m_cmd_vld  out  1  command valid to master
m_cmd_rdy  in  1  master idle/ready; drops while busy
m_read_vld  in  1  master read-data strobe
m_read_data  in  READ_WIDTH  master read data
busy  out  1  high in every state except IDLE
grant_id  out  $clog2(NUM_REQ)  index of current or last grant

Behaviour:
- Single clock clk. Synchronous active-low reset rst_n, sampled on the rising clk edge only.
- Reset: state=IDLE; req_rdy=0, rsp_vld=0, rsp_data=0, rsp_err=0, m_cmd_vld=0, m_cmd=0, busy=0, grant_id=0.
- Reset also sets last_grant=NUM_REQ-1 so that requester 0 wins first. Timeout counter=0.
- IDLE:
  - Winner = first i with req_vld[i], searching from last_grant+1 upward with wrap.
  - req_rdy[winner]=1 combinationally, in IDLE only.
  - On that cycle: latch req_cmd slice into cmd_buf, winner into grant_id; go to ISSUE.
  - No req_vld: stay in IDLE with req_rdy=0.
- ISSUE:
  - m_cmd_vld=1, m_cmd=cmd_buf. Counter is cleared on entry.
  - m_cmd_vld&&m_cmd_rdy -> WAIT_BUSY; m_cmd_vld drops the next cycle.
- WAIT_BUSY: m_cmd_rdy=0 -> WAIT_DONE. This confirms the master accepted the command.
- WAIT_DONE:
  - Write: m_cmd_rdy=1 -> RESP with rsp_data=0.
  - Read: m_read_vld=1 -> capture m_read_data -> RESP.
  - m_read_vld during a write, or in any other state, is ignored.
- RESP:
  - rsp_vld[grant_id]=1 for exactly one cycle, together with registered rsp_data and rsp_err.
  - last_grant<=grant_id; -> IDLE.
  - Minimum requester-to-requester turnaround: IDLE->ISSUE->WAIT_BUSY->WAIT_DONE->RESP->IDLE, 5 cycles plus master time.
- Timeout:
  - Counter increments each cycle in ISSUE, WAIT_BUSY and WAIT_DONE.
  - Reaching TIMEOUT -> RESP with rsp_err=1, rsp_data=0, m_cmd_vld forced 0.
  - If completion and timeout occur in the same cycle, completion wins (rsp_err=0).
- Fairness: a requester that was just served has lowest priority next round; every requester holding req_vld is served within NUM_REQ grants.
- req_vld deassert: dropping req_vld after acceptance has no effect. Dropping it before acceptance withdraws the request.
- Reset mid-operation: all outputs return to reset values within one cycle. No rsp_vld is emitted for the aborted command.
- cmd_buf: stable from acceptance through RESP; req_cmd changes after acceptance are not observed.

Decomposition:
- Shared package spi_pkg holds:
  - state localparams IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP (3-bit encoding);
  - CMD_RW_BIT = CMD_WIDTH-1;
  - default widths CMD_WIDTH=12, READ_WIDTH=8.
- One sub-module, spi_rr_arbiter: combinational round-robin pick from req_vld and last_grant, outputting one-hot grant plus index. It is reusable by other shared-resource controllers.

Test Plan:
- Write from requester 0, cmd 0x8A5 (bit11=1); master drops m_cmd_rdy 1 cycle after accept and raises it 40 cycles later -> m_cmd=0x8A5; rsp_vld[0] pulses once; rsp_data=0; rsp_err=0.
- Read from requester 2, cmd 0x345; master returns m_read_vld with 0xA5 -> rsp_vld[2] pulses; rsp_data=0xA5; rsp_err=0; no pulse on other rsp_vld bits.
- All 4 req_vld held high from reset -> grant order 0,1,2,3,0; each grant preceded by exactly one req_rdy pulse.
- last grant=2, requests pending on 1 and 3 -> 3 served before 1.
- Master never drops m_cmd_rdy after accept -> rsp_vld pulses with rsp_err=1, rsp_data=0, TIMEOUT cycles after ISSUE entry; arbiter returns to IDLE and serves the next request.
- rst_n low for 1 cycle during WAIT_DONE of a read -> next cycle busy=0, m_cmd_vld=0, no rsp_vld; the following request from requester 3 is granted only after requester 0 if both are pending.
